// File: rtl/shiftreg_delay_calibrator.sv
// Measures the round-trip latency of an external delay path by sending a marker word and counting cycles until it returns.
// Latency per pass: (MAX_DELAY_LENGTH+1) + 1 + (d+1) + 1 cycles; no backpressure, and START is only honoured while idle.
module shiftreg_delay_calibrator #(
  parameter int                    DATA_WIDTH       = 16,
  parameter int                    MAX_DELAY_LENGTH = 16,
  parameter int                    REPEAT           = 4,
  parameter logic [DATA_WIDTH-1:0] MARKER           = 16'hA5C3,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD        = 16'h0000,
  localparam int                   CW               = $clog2(MAX_DELAY_LENGTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_sample_in,
  output logic [DATA_WIDTH-1:0] o_pattern_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic                  o_error,
  output logic [CW-1:0]         o_measured_delay,
  output logic                  o_valid
);

  localparam int            RW       = $clog2(REPEAT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DELAY_LENGTH);
  localparam logic [RW-1:0] LAST_REP = RW'(REPEAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SEND,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [RW-1:0]         r_rep;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [CW-1:0]         r_result;
  logic [CW-1:0]         r_ref;
  logic                  r_mismatch;
  logic [DATA_WIDTH-1:0] r_pattern;
  logic                  r_done;
  logic                  r_timeout;
  logic                  r_error;
  logic [CW-1:0]         r_meas;
  logic                  r_valid;

  logic                  w_hit;
  logic                  w_cnt_max;
  logic                  w_last;
  logic                  w_pass_diff;
  logic [CW-1:0]         w_ref;

  // SAMPLE_IN is registered, so a marker captured at edge En is judged in WAIT cycle n.
  assign w_hit       = (r_sample == MARKER);
  assign w_cnt_max   = (r_cnt == CNT_MAX);
  assign w_last      = (r_rep == LAST_REP);
  assign w_pass_diff = (r_rep != '0) && (r_result != r_ref);
  assign w_ref       = (r_rep == '0) ? r_result : r_ref;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_cnt_max) w_next = S_SEND;
      end
      S_SEND: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_hit) begin
          w_next = S_CHECK;
        end else if (w_cnt_max) begin
          w_next = S_IDLE;
        end
      end
      S_CHECK: begin
        w_next = w_last ? S_IDLE : S_FLUSH;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt      <= '0;
      r_rep      <= '0;
      r_sample   <= IDLE_WORD;
      r_result   <= '0;
      r_ref      <= '0;
      r_mismatch <= 1'b0;
      r_pattern  <= IDLE_WORD;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_error    <= 1'b0;
      r_meas     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_sample  <= i_sample_in;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_error   <= 1'b0;
      r_pattern <= (w_next == S_SEND) ? MARKER : IDLE_WORD;

      // One counter serves FLUSH length and WAIT delay; it restarts on every state change.
      if (r_state != w_next) begin
        r_cnt <= '0;
      end else if (!w_cnt_max) begin
        r_cnt <= r_cnt + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rep      <= '0;
            r_mismatch <= 1'b0;
          end
        end
        S_WAIT: begin
          if (w_hit) begin
            r_result <= r_cnt;
          end else if (w_cnt_max) begin
            r_timeout <= 1'b1;
            r_valid   <= 1'b0;
          end
        end
        S_CHECK: begin
          if (r_rep == '0) r_ref <= r_result;
          if (w_pass_diff) r_mismatch <= 1'b1;
          r_rep <= w_last ? '0 : r_rep + RW'(1);
          if (w_last) begin
            r_done <= 1'b1;
            if (r_mismatch || w_pass_diff) begin
              r_error <= 1'b1;
              r_valid <= 1'b0;
            end else begin
              r_meas  <= w_ref;
              r_valid <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_pattern_out    = r_pattern;
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = r_done;
  assign o_timeout        = r_timeout;
  assign o_error          = r_error;
  assign o_measured_delay = r_meas;
  assign o_valid          = r_valid;

endmodule

// File: tb/tb_shiftreg_delay_calibrator.sv
// Bench for shiftreg_delay_calibrator: a configurable delay line loops PATTERN_OUT back to SAMPLE_IN; expected results are queued per calibration.
module tb_shiftreg_delay_calibrator;

  localparam int          DW    = 16;
  localparam int          MAXD  = 16;
  localparam int          REP   = 4;
  localparam logic [15:0] MARK  = 16'hA5C3;
  localparam logic [15:0] IDLEW = 16'h0000;

  typedef struct {
    bit         done;
    bit         err;
    bit         to;
    logic [4:0] meas;
    bit         valid;
    int         busy;
  } exp_t;

  typedef struct {
    bit         seen;
    bit         done;
    bit         err;
    bit         to;
    logic [4:0] meas;
    bit         valid;
    int         busy;
    bit         busy_at_pulse;
    int         extra;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] sample_in;
  logic [DW-1:0] pattern_out;
  logic          busy, done, tmo, err, valid;
  logic [4:0]    meas;

  int            total = 0;
  int            bad   = 0;
  exp_t          sb[$];
  logic [4:0]    m_meas;
  bit            m_valid;

  logic [DW-1:0] hist [0:MAXD];
  int            cur_d;
  bit            tie_idle;

  always #5 clk = ~clk;

  shiftreg_delay_calibrator #(
    .DATA_WIDTH(DW), .MAX_DELAY_LENGTH(MAXD), .REPEAT(REP), .MARKER(MARK), .IDLE_WORD(IDLEW)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_start         (start),
    .i_sample_in     (sample_in),
    .o_pattern_out   (pattern_out),
    .o_busy          (busy),
    .o_done          (done),
    .o_timeout       (tmo),
    .o_error         (err),
    .o_measured_delay(meas),
    .o_valid         (valid)
  );

  // Delay-line model of the path under test.
  always @(posedge clk) begin
    hist[0] <= pattern_out;
    for (int i = 1; i <= MAXD; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    if (tie_idle)        sample_in = IDLEW;
    else if (cur_d == 0) sample_in = pattern_out;
    else                 sample_in = hist[cur_d-1];
  end

  function automatic int pass_cycles(input int d);
    return (MAXD + 1) + 1 + (d + 1) + 1;
  endfunction

  task automatic push_done(input int d_ref, input bit consistent, input int busy_cycles);
    exp_t e;
    if (consistent) begin
      m_meas  = 5'(d_ref);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    e.done = 1'b1; e.err = !consistent; e.to = 1'b0;
    e.meas = m_meas; e.valid = m_valid; e.busy = busy_cycles;
    sb.push_back(e);
  endtask

  task automatic push_timeout();
    exp_t e;
    m_valid = 1'b0;
    e.done = 1'b0; e.err = 1'b0; e.to = 1'b1;
    e.meas = m_meas; e.valid = m_valid; e.busy = (MAXD + 1) + 1 + (MAXD + 1);
    sb.push_back(e);
  endtask

  // Drives one calibration and records what the DUT did; k counts cycles from the first FLUSH cycle.
  task automatic calibrate(input int d, input bit tie, input int switch_k, input int d2,
                           input int poke_k, output obs_t o);
    o.seen = 0; o.done = 0; o.err = 0; o.to = 0; o.meas = '0; o.valid = 0;
    o.busy = 0; o.busy_at_pulse = 0; o.extra = 0;
    cur_d = d; tie_idle = tie;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k == switch_k) cur_d = d2;
      start = (k == poke_k);
      if (done || tmo) begin
        o.seen = 1; o.done = done; o.err = err; o.to = tmo;
        o.meas = meas; o.valid = valid; o.busy_at_pulse = busy;
        break;
      end
      if (busy) o.busy++;
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || tmo || err) o.extra++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cur_d = 0; tie_idle = 0;
    m_meas = '0; m_valid = 0;
    repeat (20) @(negedge clk);
    total++; if (pattern_out !== IDLEW) begin bad++; $display("FAIL rst_pattern: got %h want %h", pattern_out, IDLEW); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", tmo); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", err); end
    total++; if (meas !== 5'd0) begin bad++; $display("FAIL rst_meas: got %0d want 0", meas); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_delay();
    obs_t o; exp_t e;
    push_done(0, 1, REP * pass_cycles(0));
    calibrate(0, 0, -1, 0, -1, o);
    e = sb.pop_front();
    total++; if (!o.seen) begin bad++; $display("FAIL d0_bound: got no pulse want done"); end
    total++; if (o.done !== e.done) begin bad++; $display("FAIL d0_done: got %b want %b", o.done, e.done); end
    total++; if (o.err !== e.err) begin bad++; $display("FAIL d0_error: got %b want %b", o.err, e.err); end
    total++; if (o.meas !== e.meas) begin bad++; $display("FAIL d0_meas: got %0d want %0d", o.meas, e.meas); end
    total++; if (o.valid !== e.valid) begin bad++; $display("FAIL d0_valid: got %b want %b", o.valid, e.valid); end
    total++; if (o.busy !== e.busy) begin bad++; $display("FAIL d0_busy_cycles: got %0d want %0d", o.busy, e.busy); end
  endtask

  task automatic test_loopback_d5();
    obs_t o; exp_t e;
    push_done(5, 1, REP * pass_cycles(5));
    calibrate(5, 0, -1, 0, -1, o);
    e = sb.pop_front();
    total++; if (!o.seen) begin bad++; $display("FAIL d5_bound: got no pulse want done"); end
    total++; if (o.done !== e.done) begin bad++; $display("FAIL d5_done: got %b want %b", o.done, e.done); end
    total++; if (o.err !== e.err) begin bad++; $display("FAIL d5_error: got %b want %b", o.err, e.err); end
    total++; if (o.to !== e.to) begin bad++; $display("FAIL d5_timeout: got %b want %b", o.to, e.to); end
    total++; if (o.meas !== e.meas) begin bad++; $display("FAIL d5_meas: got %0d want %0d", o.meas, e.meas); end
    total++; if (o.valid !== e.valid) begin bad++; $display("FAIL d5_valid: got %b want %b", o.valid, e.valid); end
    total++; if (o.busy !== e.busy) begin bad++; $display("FAIL d5_busy_cycles: got %0d want %0d", o.busy, e.busy); end
    total++; if (o.busy_at_pulse !== 1'b0) begin bad++; $display("FAIL d5_busy_on_done: got %b want 0", o.busy_at_pulse); end
    total++; if (o.extra !== 0) begin bad++; $display("FAIL d5_extra_pulses: got %0d want 0", o.extra); end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    push_timeout();
    calibrate(0, 1, -1, 0, -1, o);
    e = sb.pop_front();
    total++; if (!o.seen) begin bad++; $display("FAIL to_bound: got no pulse want timeout"); end
    total++; if (o.to !== e.to) begin bad++; $display("FAIL to_timeout: got %b want %b", o.to, e.to); end
    total++; if (o.done !== e.done) begin bad++; $display("FAIL to_done: got %b want %b", o.done, e.done); end
    total++; if (o.meas !== e.meas) begin bad++; $display("FAIL to_meas_hold: got %0d want %0d", o.meas, e.meas); end
    total++; if (o.valid !== e.valid) begin bad++; $display("FAIL to_valid: got %b want %b", o.valid, e.valid); end
    total++; if (o.busy !== e.busy) begin bad++; $display("FAIL to_busy_cycles: got %0d want %0d", o.busy, e.busy); end
    total++; if (o.busy_at_pulse !== 1'b0) begin bad++; $display("FAIL to_busy_on_pulse: got %b want 0", o.busy_at_pulse); end
    total++; if (o.extra !== 0) begin bad++; $display("FAIL to_extra_pulses: got %0d want 0", o.extra); end
    tie_idle = 0;
  endtask

  task automatic test_boundary_d16();
    obs_t o; exp_t e;
    push_done(MAXD, 1, REP * pass_cycles(MAXD));
    calibrate(MAXD, 0, -1, 0, 25, o);
    e = sb.pop_front();
    total++; if (!o.seen) begin bad++; $display("FAIL d16_bound: got no pulse want done"); end
    total++; if (o.done !== e.done) begin bad++; $display("FAIL d16_done: got %b want %b", o.done, e.done); end
    total++; if (o.to !== e.to) begin bad++; $display("FAIL d16_timeout: got %b want %b", o.to, e.to); end
    total++; if (o.meas !== e.meas) begin bad++; $display("FAIL d16_meas: got %0d want %0d", o.meas, e.meas); end
    total++; if (o.valid !== e.valid) begin bad++; $display("FAIL d16_valid: got %b want %b", o.valid, e.valid); end
    total++; if (o.busy !== e.busy) begin bad++; $display("FAIL d16_busy_cycles: got %0d want %0d", o.busy, e.busy); end
    total++; if (o.extra !== 0) begin bad++; $display("FAIL d16_extra_pulses: got %0d want 0", o.extra); end
  endtask

  task automatic test_mismatch();
    obs_t o; exp_t e;
    push_done(0, 0, pass_cycles(3) + (REP - 1) * pass_cycles(7));
    calibrate(3, 0, 30, 7, -1, o);
    e = sb.pop_front();
    total++; if (!o.seen) begin bad++; $display("FAIL mm_bound: got no pulse want done"); end
    total++; if (o.done !== e.done) begin bad++; $display("FAIL mm_done: got %b want %b", o.done, e.done); end
    total++; if (o.err !== e.err) begin bad++; $display("FAIL mm_error: got %b want %b", o.err, e.err); end
    total++; if (o.meas !== e.meas) begin bad++; $display("FAIL mm_meas_hold: got %0d want %0d", o.meas, e.meas); end
    total++; if (o.valid !== e.valid) begin bad++; $display("FAIL mm_valid: got %b want %b", o.valid, e.valid); end
    total++; if (o.busy !== e.busy) begin bad++; $display("FAIL mm_busy_cycles: got %0d want %0d", o.busy, e.busy); end
    total++; if (o.extra !== 0) begin bad++; $display("FAIL mm_extra_pulses: got %0d want 0", o.extra); end
  endtask

  task automatic test_reset_mid_cal();
    obs_t o; exp_t e;
    int   pulses;
    bit   busy_seen;
    cur_d = 5; tie_idle = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (45) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    m_meas = '0; m_valid = 0;
    total++; if (pattern_out !== IDLEW) begin bad++; $display("FAIL rmid_pattern: got %h want %h", pattern_out, IDLEW); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if ({done, tmo, err} !== 3'b000) begin bad++; $display("FAIL rmid_pulses: got %b want 000", {done, tmo, err}); end
    total++; if (meas !== 5'd0) begin bad++; $display("FAIL rmid_meas: got %0d want 0", meas); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", valid); end
    pulses = 0; busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || tmo || err) pulses++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || tmo || err) pulses++;
      if (busy) busy_seen = 1;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rmid_no_pulse: got %0d want 0", pulses); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL rmid_no_resume: got %b want 0", busy_seen); end
    push_done(5, 1, REP * pass_cycles(5));
    calibrate(5, 0, -1, 0, -1, o);
    e = sb.pop_front();
    total++; if (!o.seen) begin bad++; $display("FAIL rmid_re_bound: got no pulse want done"); end
    total++; if (o.done !== e.done) begin bad++; $display("FAIL rmid_re_done: got %b want %b", o.done, e.done); end
    total++; if (o.meas !== e.meas) begin bad++; $display("FAIL rmid_re_meas: got %0d want %0d", o.meas, e.meas); end
    total++; if (o.valid !== e.valid) begin bad++; $display("FAIL rmid_re_valid: got %b want %b", o.valid, e.valid); end
    total++; if (o.busy !== e.busy) begin bad++; $display("FAIL rmid_re_busy_cycles: got %0d want %0d", o.busy, e.busy); end
  endtask

  initial begin
    test_reset();
    test_zero_delay();
    test_loopback_d5();
    test_timeout();
    test_boundary_d16();
    test_mismatch();
    test_reset_mid_cal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within 500000 time units want completion");
    $fatal(1);
  end

endmodule
